// File: rtl/csr_access_arbiter.sv
// Shares the single-port machine-mode CSR file between the core pipeline and the debug port.
// Each grant is one atomic read-modify-write. Define CSR_DEBUG_PORT_EN to enable the debug requester.
module csr_access_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            core_req_i,
    input  logic [11:0]     core_addr_i,
    input  logic [1:0]      core_op_i,
    input  logic [XLEN-1:0] core_wdata_i,
    output logic            core_gnt_o,
    output logic            core_rvalid_o,
    output logic [XLEN-1:0] core_rdata_o,
    output logic            core_err_o,

    input  logic            dbg_req_i,
    input  logic [11:0]     dbg_addr_i,
    input  logic [1:0]      dbg_op_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    output logic            dbg_gnt_o,
    output logic            dbg_rvalid_o,
    output logic [XLEN-1:0] dbg_rdata_o,
    output logic            dbg_err_o,

    output logic            csr_re_o,
    output logic            csr_we_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic            csr_hit_i,

    output logic [2:0]      fsm_state_o
);

    // Handshake: a requester holds req/addr/op/wdata stable until it sees gnt in the same cycle;
    // gnt is only given in IDLE and commits the inputs of that cycle. The answer is a single-cycle
    // rvalid pulse carrying rdata/err to the owner only; responses cannot be back-pressured.

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          r_state;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_wdata;
    logic [11:0]     r_addr;
    logic            r_re;
    logic            r_we;
    logic [XLEN-1:0] r_csr_wdata;
    logic            r_rvalid;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_idle;
    logic            w_core_gnt;
    logic            w_dbg_gnt;
    logic            w_any_gnt;
    logic [11:0]     w_req_addr;
    logic [1:0]      w_req_op;
    logic [XLEN-1:0] w_req_wdata;
    logic [XLEN-1:0] w_new;
    logic            w_op_writes;
    logic            w_read_only;
    logic            w_err;

    assign w_idle    = (r_state == S_IDLE);
    assign w_any_gnt = w_core_gnt | w_dbg_gnt;

`ifdef CSR_DEBUG_PORT_EN
    // r_rr_dbg_pref set means the debug port wins the next tie; reset favours the core.
    logic r_rr_dbg_pref;
    logic r_owner_dbg;

    assign w_core_gnt  = w_idle & core_req_i & (~dbg_req_i | ~r_rr_dbg_pref);
    assign w_dbg_gnt   = w_idle & dbg_req_i & (~core_req_i | r_rr_dbg_pref);
    assign w_req_addr  = w_dbg_gnt ? dbg_addr_i  : core_addr_i;
    assign w_req_op    = w_dbg_gnt ? dbg_op_i    : core_op_i;
    assign w_req_wdata = w_dbg_gnt ? dbg_wdata_i : core_wdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_dbg_pref <= 1'b0;
            r_owner_dbg   <= 1'b0;
        end else if (w_any_gnt) begin
            r_rr_dbg_pref <= w_core_gnt;
            r_owner_dbg   <= w_dbg_gnt;
        end
    end

    assign core_rvalid_o = r_rvalid & ~r_owner_dbg;
    assign core_rdata_o  = core_rvalid_o ? r_rdata : '0;
    assign core_err_o    = core_rvalid_o & r_err;
    assign dbg_gnt_o     = w_dbg_gnt;
    assign dbg_rvalid_o  = r_rvalid & r_owner_dbg;
    assign dbg_rdata_o   = dbg_rvalid_o ? r_rdata : '0;
    assign dbg_err_o     = dbg_rvalid_o & r_err;
`else
    logic w_dbg_unused;
    assign w_dbg_unused = ^{dbg_req_i, dbg_addr_i, dbg_op_i, dbg_wdata_i};

    assign w_core_gnt  = w_idle & core_req_i;
    assign w_dbg_gnt   = 1'b0;
    assign w_req_addr  = core_addr_i;
    assign w_req_op    = core_op_i;
    assign w_req_wdata = core_wdata_i;

    assign core_rvalid_o = r_rvalid;
    assign core_rdata_o  = r_rvalid ? r_rdata : '0;
    assign core_err_o    = r_rvalid & r_err;
    assign dbg_gnt_o     = 1'b0;
    assign dbg_rvalid_o  = 1'b0;
    assign dbg_rdata_o   = '0;
    assign dbg_err_o     = 1'b0;
`endif

    assign core_gnt_o = w_core_gnt;

    always_comb begin
        w_new = r_wdata;
        case (r_op)
            OP_SET:   w_new = csr_rdata_i | r_wdata;
            OP_CLEAR: w_new = csr_rdata_i & ~r_wdata;
            default:  w_new = r_wdata;
        endcase
    end

    // Set/clear with an all-zero mask is a pure read, so it is legal on read-only CSRs.
    assign w_op_writes = (r_op == OP_WRITE) | (r_op[1] & (r_wdata != '0));
    assign w_read_only = (r_addr[11:10] == 2'b11);
    assign w_err       = ~csr_hit_i | (w_op_writes & w_read_only);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_READ;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_re        <= 1'b0;
            r_we        <= 1'b0;
            r_csr_wdata <= '0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_re <= 1'b0;
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_gnt) begin
                        r_op    <= w_req_op;
                        r_wdata <= w_req_wdata;
                        r_addr  <= w_req_addr;
                        r_re    <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_err   <= w_err;
                    r_rdata <= w_err ? '0 : csr_rdata_i;
                    if (w_err || !w_op_writes) begin
                        r_rvalid <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_we        <= 1'b1;
                        r_csr_wdata <= w_new;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_rvalid <= 1'b1;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    r_rvalid <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_rvalid <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign csr_re_o    = r_re;
    assign csr_we_o    = r_we;
    assign csr_addr_o  = r_addr;
    assign csr_wdata_o = r_csr_wdata;
    assign fsm_state_o = r_state;

endmodule

// File: doc/csr_access_arbiter.md
# csr_access_arbiter

Sequences and shares the single-port machine-mode CSR file between two requesters: the core pipeline (CSR instructions) and the debug port. Each accepted request is executed as an atomic read-modify-write (CSRRW/CSRRS/CSRRC semantics) over the CSR file's read and write strobes. Writes to read-only and unimplemented addresses are rejected with an error. The block sits between the decode/execute stage plus debug module and the CSR register file.

## Interface
- XLEN, 32, CSR data width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req_i  in  1  core request, held until core_gnt_o
- core_addr_i  in  12  CSR address (csr::t encoding)
- core_op_i  in  2  00 read, 01 write, 10 set, 11 clear
- core_wdata_i  in  XLEN  write value or set/clear mask
- core_gnt_o  out  1  request accepted; inputs sampled this cycle
- core_rvalid_o  out  1  one-cycle response strobe
- core_rdata_o  out  XLEN  old CSR value (0 on error)
- core_err_o  out  1  access error, valid with rvalid
- dbg_req_i, dbg_addr_i, dbg_op_i, dbg_wdata_i, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o: same as core_*
- csr_re_o  out  1  CSR file read strobe
- csr_we_o  out  1  CSR file write strobe
- csr_addr_o  out  12  CSR file address
- csr_wdata_o  out  XLEN  CSR file write data
- csr_rdata_i  in  XLEN  read data, valid the cycle after csr_re_o
- csr_hit_i  in  1  address implemented, valid with csr_rdata_i

## Operation
- FSM states: IDLE, READ, CHECK, WRITE, RESP.
- IDLE: if any req, assert gnt to the winner (combinational), latch owner/addr/op/wdata, go READ. No req: stay.
- READ: csr_re_o=1, csr_addr_o=latched addr; go CHECK.
- CHECK: capture csr_rdata_i as old, compute new: write → wdata; set → old|wdata; clear → old&~wdata.
  - err if !csr_hit_i, or (op writes and addr[11:10]==2'b11).
  - op writes = write, or set/clear with wdata!=0. Set/clear with mask 0 is a pure read, never an error for read-only CSRs.
  - err or no write → RESP; else → WRITE.
- WRITE: csr_we_o=1, csr_wdata_o=new; go RESP.
- RESP: owner's rvalid=1, rdata=old (0 if err), err; go IDLE.
- Arbitration: round-robin. With both req in IDLE, grant the requester not granted last. Pointer reset favours core. Single req always wins.
- gnt only in IDLE; requests in other states wait. Non-owner rvalid/err/rdata stay 0.
- Exactly one transaction in flight; never more than one csr_we_o per transaction.

## Timing
- Request granted in cycle N: csr_re_o at N+1, rdata sampled at N+2, csr_we_o at N+3, rvalid at N+4.
- No-write or error path: rvalid at N+3, csr_we_o never asserted.
- Next grant earliest the cycle after RESP (N+5 / N+4). Back-to-back throughput: 1 transaction per 5 cycles.
- csr_addr_o held stable from READ through WRITE.
- Reset values: all *_gnt_o, *_rvalid_o, *_err_o, csr_re_o, csr_we_o = 0; all rdata, csr_addr_o, csr_wdata_o = 0; state IDLE; pointer = core.
- rst_n asserted mid-transaction: immediate return to IDLE, no write or response issued; the requester must reissue.

## Configuration
- CSR_DEBUG_PORT_EN defined: debug port arbitrated as above.
- Undefined: dbg_req_i ignored; dbg_gnt_o, dbg_rvalid_o, dbg_err_o, dbg_rdata_o tied 0; core always wins; no round-robin pointer state.

## Test plan
- Core write MSCRATCH (0x340) 0xDEADBEEF, file holds 0 → csr_we_o at N+3 with 0xDEADBEEF, core_rvalid_o at N+4, rdata 0, err 0.
- Core set MSTATUS (0x300) mask 0, file holds 0x1800 → no csr_we_o, rvalid at N+3, rdata 0x1800; set mask 0x8 → write 0x1808.
- Core write MHARTID (0xF14) 0x5 → err=1, rdata 0, no csr_we_o; read MHARTID → err=0, returns file value.
- Read 0x7C0 with csr_hit_i=0 → err=1, rdata 0, no write.
- Core and dbg req together for three transactions → grants core, dbg, core; each rvalid only to its owner. Without CSR_DEBUG_PORT_EN → dbg never granted.
- rst_n low during WRITE-bound transaction at N+2 → no csr_we_o, no rvalid, all outputs 0; next request completes normally.
